// File: rtl/counter.sv
// Parameterised up/down binary counter with synchronous clear, parallel load,
// count enable and a registered one-cycle wrap pulse.
module counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             dn,
    input  logic             ld,
    input  logic [15:0]      ld_val,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    localparam int LD_BITS = (WIDTH < 16) ? WIDTH : 16;

    logic [WIDTH-1:0] r_count;
    logic             r_overflow;

    logic [WIDTH-1:0] w_ld_val;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_overflow_nxt;
    logic             w_at_max;
    logic             w_at_zero;

    // The load bus is fixed at 16 bits; zero-extend or truncate to WIDTH.
    always_comb begin
        w_ld_val                = '0;
        w_ld_val[LD_BITS-1:0]   = ld_val[LD_BITS-1:0];
    end

    assign w_at_max  = &r_count;
    assign w_at_zero = ~|r_count;

    // NOTE: every output of this block gets a default first, so no path
    // through the if/else chain can leave a value unassigned and infer a latch.
    always_comb begin
        w_count_nxt    = r_count;
        w_overflow_nxt = 1'b0;
        if (clr) begin
            w_count_nxt = '0;
        end else if (ld) begin
            w_count_nxt = w_ld_val;
        end else if (en) begin
            if (dn) begin
                w_count_nxt    = r_count - WIDTH'(1);
                w_overflow_nxt = w_at_zero;
            end else begin
                w_count_nxt    = r_count + WIDTH'(1);
                w_overflow_nxt = w_at_max;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    assign count    = r_count;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench: three widths (4, 20, 1) share one stimulus stream and are
// compared every edge against an arithmetic reference model.
module tb_counter;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        en;
    logic        dn;
    logic        ld;
    logic [15:0] ld_val;

    logic [3:0]  count4;
    logic        ovf4;
    logic [19:0] count20;
    logic        ovf20;
    logic [0:0]  count1;
    logic        ovf1;

    int n_vec = 0;
    int n_err = 0;

    longint m_c4, m_c20, m_c1;
    bit     m_o4, m_o20, m_o1;

    counter #(4) u4 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .dn(dn), .ld(ld),
        .ld_val(ld_val), .count(count4), .overflow(ovf4)
    );

    counter #(20) u20 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .dn(dn), .ld(ld),
        .ld_val(ld_val), .count(count20), .overflow(ovf20)
    );

    counter #(1) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .dn(dn), .ld(ld),
        .ld_val(ld_val), .count(count1), .overflow(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: the counter value is an integer modulo 2^w; wrap is detected
    // by whether the arithmetic result left the range [0, 2^w - 1].
    function automatic void ref_next(input int w, input longint c,
                                     output longint n, output bit o);
        longint modulus;
        longint raw;
        modulus = longint'(1) << w;
        o = 1'b0;
        n = c;
        if (clr) begin
            n = 0;
        end else if (ld) begin
            n = longint'(ld_val) % modulus;
        end else if (en) begin
            raw = dn ? c - 1 : c + 1;
            o   = (raw < 0) || (raw >= modulus);
            n   = (raw + modulus) % modulus;
        end
    endfunction

    task automatic model_edge();
        longint n;
        bit     o;
        if (!rst_n) begin
            m_c4 = 0; m_c20 = 0; m_c1 = 0;
            m_o4 = 0; m_o20 = 0; m_o1 = 0;
        end else begin
            ref_next(4,  m_c4,  n, o); m_c4  = n; m_o4  = o;
            ref_next(20, m_c20, n, o); m_c20 = n; m_o20 = o;
            ref_next(1,  m_c1,  n, o); m_c1  = n; m_o1  = o;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".c4"},  32'(count4),  32'(m_c4));
        check({tag, ".o4"},  32'(ovf4),    32'(m_o4));
        check({tag, ".c20"}, 32'(count20), 32'(m_c20));
        check({tag, ".o20"}, 32'(ovf20),   32'(m_o20));
        check({tag, ".c1"},  32'(count1),  32'(m_c1));
        check({tag, ".o1"},  32'(ovf1),    32'(m_o1));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic c, input logic l, input logic e,
                         input logic d, input logic [15:0] v);
        clr = c; ld = l; en = e; dn = d; ld_val = v;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 16'h0000);
        m_c4 = 0; m_c20 = 0; m_c1 = 0;
        m_o4 = 0; m_o20 = 0; m_o1 = 0;
        #2;
        check_all("reset_initial");
        step("reset_held");
        #2 rst_n = 1'b1;

        // Asynchronous reset mid-cycle with count = 9.
        drive(0, 1, 0, 0, 16'h0009);
        step("load9");
        check("load9_c4", 32'(count4), 32'd9);
        drive(0, 0, 1, 0, 16'h0000);
        #2 rst_n = 1'b0;
        #1;
        model_edge();
        check_all("async_reset");
        check("async_reset_c4", 32'(count4), 32'd0);
        #1 rst_n = 1'b1;
        step("rel1"); check("rel1_c4", 32'(count4), 32'd1);
        step("rel2"); check("rel2_c4", 32'(count4), 32'd2);
        step("rel3"); check("rel3_c4", 32'(count4), 32'd3);

        // Up wrap from 14.
        drive(0, 1, 0, 0, 16'h000E);
        step("ld14");
        drive(0, 0, 1, 0, 16'h0000);
        step("up15");   check("up15_c4", 32'(count4), 32'd15);
        step("upwrap"); check("upwrap_c4", 32'(count4), 32'd0);
                        check("upwrap_o4", 32'(ovf4), 32'd1);
        step("up1");    check("up1_o4", 32'(ovf4), 32'd0);

        // Down wrap from 1.
        drive(0, 1, 0, 0, 16'h0001);
        step("ld1");
        drive(0, 0, 1, 1, 16'h0000);
        step("dn0");    check("dn0_c4", 32'(count4), 32'd0);
        step("dnwrap"); check("dnwrap_c4", 32'(count4), 32'd15);
                        check("dnwrap_o4", 32'(ovf4), 32'd1);
                        check("dnwrap_c20", 32'(count20), 32'hFFFFF);
                        check("dnwrap_o20", 32'(ovf20), 32'd1);
        step("dn14");   check("dn14_c4", 32'(count4), 32'd14);

        // Priority: clr over ld over en.
        drive(1, 1, 1, 0, 16'h00A5);
        step("prio_clr"); check("prio_clr_c20", 32'(count20), 32'd0);
        drive(0, 1, 1, 0, 16'h00A5);
        step("prio_ld");  check("prio_ld_c20", 32'(count20), 32'hA5);
                          check("prio_ld_o20", 32'(ovf20), 32'd0);

        // Hold for 5 cycles.
        drive(0, 0, 0, 1, 16'h0000);
        for (int i = 0; i < 5; i++) step("hold");
        check("hold_c20", 32'(count20), 32'hA5);

        // Resize; loading a wrap boundary never pulses overflow.
        drive(0, 1, 1, 0, 16'h123F);
        step("trunc");  check("trunc_c4", 32'(count4), 32'hF);
                        check("trunc_o4", 32'(ovf4), 32'd0);
        drive(0, 1, 0, 0, 16'hFFFF);
        step("zext");   check("zext_c20", 32'(count20), 32'h0FFFF);

        // Up wrap at 20 bits, reached via a down wrap from 0.
        drive(0, 1, 0, 0, 16'h0000);
        step("ld0");
        drive(0, 0, 1, 1, 16'h0000);
        step("w20_dn");
        drive(0, 0, 1, 0, 16'h0000);
        step("w20_up"); check("w20_up_c20", 32'(count20), 32'd0);
                        check("w20_up_o20", 32'(ovf20), 32'd1);

        // Display configuration: free-running up; WIDTH=1 pulses every 2nd edge.
        drive(0, 0, 1, 0, 16'h0000);
        for (int i = 0; i < 40; i++) step("display");

        // Randomised phase.
        for (int i = 0; i < 3000; i++) begin
            clr = ($urandom_range(0, 63) == 0);
            ld  = ($urandom_range(0, 15) == 0);
            en  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) dn = ~dn;
            case ($urandom_range(0, 3))
                0:       ld_val = 16'hFFFF;
                1:       ld_val = 16'h0000;
                default: ld_val = 16'($urandom);
            endcase
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
